instr_fetch_sequencer: RTL and testbench

Parametrised instruction-fetch state machine for the SAP-2 CPU control path, generalising the fixed multi-byte fetch loop to instructions of 1..MAX_BYTES bytes with optional memory wait states. It sits between the opcode decoder and the microstep sequencer inside the control unit. It drives the PC/MAR/IR/temp-register strobes for each fetched byte, then hands off to execution and waits for completion.

---
 rtl/instr_fetch_sequencer.sv | 154 +++++++++++++++
 tb/tb_instr_fetch_sequencer.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_sequencer.sv
// rtl/instr_fetch_sequencer.sv - multi-byte instruction fetch sequencer for the SAP-2 control unit
// Optional memory wait states in READ_BYTE are enabled by defining FETCH_WAIT_STATES_EN.
module instr_fetch_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BYTES  = 3,
    parameter int LEN_W      = $clog2(MAX_BYTES + 1)
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic [LEN_W-1:0]                              instr_len,
    input  logic                                          is_halt,
    input  logic                                          exec_done,
    input  logic                                          mem_ready,
    output logic                                          load_origin,
    output logic                                          load_mar_pc,
    output logic                                          mem_read,
    output logic                                          oe_ram,
    output logic                                          load_ir,
    output logic [((MAX_BYTES > 1) ? MAX_BYTES-1 : 1)-1:0] load_temp,
    output logic                                          pc_enable,
    output logic                                          exec_start,
    output logic [LEN_W-1:0]                              byte_index,
    output logic                                          halted
);

    localparam int TEMP_W = (MAX_BYTES > 1) ? MAX_BYTES - 1 : 1;
    localparam logic [TEMP_W-1:0] TEMP_ONE = TEMP_W'(1);

    typedef enum logic [2:0] {
        INIT,
        LATCH_ADDRESS,
        READ_BYTE,
        LATCH_BYTE,
        CHK_MORE_BYTES,
        EXECUTE,
        HALTED
    } state_t;

    state_t           state, state_nx;
    logic [LEN_W-1:0] byte_index_nx;
    logic [LEN_W-1:0] len_reg, len_reg_nx;
    logic [LEN_W-1:0] len_clamped;
    logic [LEN_W-1:0] eff_len;
    logic [LEN_W-1:0] temp_sel;
    logic             exec_first;

    logic [DATA_WIDTH-1:0] unused_bus_width;
    assign unused_bus_width = '0;

`ifndef FETCH_WAIT_STATES_EN
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= INIT;
            byte_index <= '0;
            len_reg    <= '0;
            exec_first <= 1'b0;
        end else begin
            state      <= state_nx;
            byte_index <= byte_index_nx;
            len_reg    <= len_reg_nx;
            exec_first <= (state_nx == EXECUTE) && (state != EXECUTE);
        end
    end

    // Length from the decoder is only trusted on byte 0; 0 means a bare opcode.
    always_comb begin
        len_clamped = instr_len;
        if (instr_len == '0) begin
            len_clamped = LEN_W'(1);
        end else if (instr_len > LEN_W'(MAX_BYTES)) begin
            len_clamped = LEN_W'(MAX_BYTES);
        end
        eff_len  = (byte_index == '0) ? len_clamped : len_reg;
        temp_sel = byte_index - LEN_W'(1);
    end

    always_comb begin
        state_nx      = state;
        byte_index_nx = byte_index;
        len_reg_nx    = len_reg;
        load_origin   = 1'b0;
        load_mar_pc   = 1'b0;
        mem_read      = 1'b0;
        oe_ram        = 1'b0;
        load_ir       = 1'b0;
        load_temp     = '0;
        pc_enable     = 1'b0;
        exec_start    = 1'b0;
        halted        = 1'b0;

        case (state)
            INIT: begin
                load_origin   = 1'b1;
                byte_index_nx = '0;
                state_nx      = LATCH_ADDRESS;
            end
            LATCH_ADDRESS: begin
                load_mar_pc = 1'b1;
                state_nx    = READ_BYTE;
            end
            READ_BYTE: begin
                mem_read = 1'b1;
`ifdef FETCH_WAIT_STATES_EN
                if (mem_ready) begin
                    state_nx = LATCH_BYTE;
                end
`else
                state_nx = LATCH_BYTE;
`endif
            end
            LATCH_BYTE: begin
                oe_ram    = 1'b1;
                pc_enable = 1'b1;
                if (byte_index == '0) begin
                    load_ir = 1'b1;
                end else begin
                    load_temp = TEMP_ONE << temp_sel;
                end
                state_nx = CHK_MORE_BYTES;
            end
            CHK_MORE_BYTES: begin
                if (byte_index == '0) begin
                    len_reg_nx = len_clamped;
                end
                if (({1'b0, byte_index} + (LEN_W+1)'(1)) < {1'b0, eff_len}) begin
                    byte_index_nx = byte_index + LEN_W'(1);
                    state_nx      = LATCH_ADDRESS;
                end else begin
                    state_nx = EXECUTE;
                end
            end
            EXECUTE: begin
                exec_start = exec_first;
                if (is_halt) begin
                    state_nx = HALTED;
                end else if (exec_done) begin
                    byte_index_nx = '0;
                    state_nx      = LATCH_ADDRESS;
                end
            end
            HALTED: begin
                halted = 1'b1;
            end
            default: begin
                state_nx = INIT;
            end
        endcase
    end

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// tb/tb_instr_fetch_sequencer.sv - scoreboard bench for instr_fetch_sequencer
module tb_instr_fetch_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] instr_len;
    logic       is_halt, exec_done, mem_ready;
    logic       load_origin, load_mar_pc, mem_read, oe_ram, load_ir, pc_enable, exec_start, halted;
    logic [1:0] load_temp;
    logic [1:0] byte_index;

    logic       b2_reset;
    logic [1:0] b2_instr_len;
    logic       b2_load_origin, b2_load_mar_pc, b2_mem_read, b2_oe_ram, b2_load_ir;
    logic       b2_pc_enable, b2_exec_start, b2_halted;
    logic [0:0] b2_load_temp;
    logic [1:0] b2_byte_index;

    logic [11:0] obs;
    assign obs = {load_origin, load_mar_pc, mem_read, oe_ram, load_ir, load_temp,
                  pc_enable, exec_start, halted, byte_index};

    always #5 clk = ~clk;

    instr_fetch_sequencer #(.DATA_WIDTH(8), .MAX_BYTES(3)) dut (
        .clk(clk), .reset(reset), .instr_len(instr_len), .is_halt(is_halt),
        .exec_done(exec_done), .mem_ready(mem_ready), .load_origin(load_origin),
        .load_mar_pc(load_mar_pc), .mem_read(mem_read), .oe_ram(oe_ram), .load_ir(load_ir),
        .load_temp(load_temp), .pc_enable(pc_enable), .exec_start(exec_start),
        .byte_index(byte_index), .halted(halted)
    );

    instr_fetch_sequencer #(.DATA_WIDTH(8), .MAX_BYTES(2)) dut2 (
        .clk(clk), .reset(b2_reset), .instr_len(b2_instr_len), .is_halt(1'b0),
        .exec_done(1'b0), .mem_ready(1'b1), .load_origin(b2_load_origin),
        .load_mar_pc(b2_load_mar_pc), .mem_read(b2_mem_read), .oe_ram(b2_oe_ram),
        .load_ir(b2_load_ir), .load_temp(b2_load_temp), .pc_enable(b2_pc_enable),
        .exec_start(b2_exec_start), .byte_index(b2_byte_index), .halted(b2_halted)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          nbytes;
        int          ncyc;
        logic [15:0] pc;
    } exp_t;
    exp_t sb[$];

    logic [15:0] pc;
    int          fetched = 0;
    int          cyc = 0;
    bit          counting = 0;

    // PC model plus per-instruction byte/cycle tracking, scored on exec_start
    always @(negedge clk) begin
        if (reset) begin
            counting = 0;
        end else begin
            if (counting) cyc++;
            if (load_mar_pc && byte_index == 2'd0) begin
                counting = 1;
                cyc = 0;
                fetched = 0;
            end
            if (load_ir) fetched = 1;
            else if (|load_temp) fetched++;
            if (exec_start) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected_exec: exec_start with no pending instruction at %0t", $time);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (fetched !== e.nbytes || cyc !== e.ncyc || pc !== e.pc) begin
                        errors++;
                        $display("FAIL sb_exec: bytes=%0d cycles=%0d pc=%h, want bytes=%0d cycles=%0d pc=%h",
                                 fetched, cyc, pc, e.nbytes, e.ncyc, e.pc);
                    end
                end
                counting = 0;
            end
        end
        if (load_origin) pc = 16'hF000;
        else if (pc_enable) pc = pc + 16'd1;
    end

    task automatic do_reset();
        reset = 1'b1; exec_done = 1'b0; is_halt = 1'b0; mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL sb_drain: %0d pending, want 0", sb.size());
        end
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    task automatic run_instr(input logic [1:0] len, input int n, input bit imm);
        exp_t e;
        int   nla;
        bit   idx_ok, seen_t1, done;
        e.nbytes = n; e.ncyc = 4 * n; e.pc = pc + 16'(n);
        sb.push_back(e);
        instr_len = len; nla = 0; idx_ok = 1; seen_t1 = 0; done = 0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk); #1;
            exec_done = 1'b0;
            if (imm && i == 0) begin
                checks++;
                if (load_mar_pc !== 1'b1) begin
                    errors++;
                    $display("FAIL exec_1cycle: load_mar_pc=%b after exec_done, want 1", load_mar_pc);
                end
            end
            if (load_mar_pc) begin
                if (byte_index !== 2'(nla)) idx_ok = 0;
                nla++;
            end
            if (load_temp[1]) seen_t1 = 1;
            if (exec_start) done = 1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL run_timeout: len=%0d no exec_start", len);
        end
        checks++;
        if (!idx_ok || nla != n) begin
            errors++;
            $display("FAIL byte_index_seq: %0d addresses ok=%0d, want %0d in order", nla, idx_ok, n);
        end
        checks++;
        if (seen_t1 !== (n == 3)) begin
            errors++;
            $display("FAIL load_temp1: seen=%0d, want %0d", seen_t1, (n == 3));
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; b2_reset = 1'b1; b2_instr_len = 2'd3;
        instr_len = 2'd1; is_halt = 1'b0; exec_done = 1'b0; mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (obs !== 12'h800) begin
            errors++;
            $display("FAIL reset_outputs: %h, want 800", obs);
        end
        checks++;
        if (halted !== 1'b0 || exec_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: halted=%b exec_start=%b, want 0 0", halted, exec_start);
        end
    endtask

    task automatic test_clamp();
        int xs_c, nbytes;
        xs_c = 0; nbytes = 0;
        @(negedge clk);
        b2_reset = 1'b0;
        #1;
        for (int c = 1; c <= 30 && xs_c == 0; c++) begin
            if (c > 1) begin @(negedge clk); #1; end
            if (b2_load_ir || b2_load_temp[0]) nbytes++;
            if (b2_exec_start) xs_c = c;
        end
        checks++;
        if (xs_c !== 10 || nbytes !== 2) begin
            errors++;
            $display("FAIL clamp_len: exec_start cycle %0d bytes %0d, want 10 and 2", xs_c, nbytes);
        end
        checks++;
        if (b2_halted !== 1'b0) begin
            errors++;
            $display("FAIL clamp_halted: %b, want 0", b2_halted);
        end
        b2_reset = 1'b1;
    endtask

    task automatic test_ldi();
        logic [11:0] tbl [1:10];
        exp_t e;
        bit   got;
        tbl[1] = 12'h800; tbl[2] = 12'h400; tbl[3] = 12'h200; tbl[4] = 12'h190; tbl[5] = 12'h000;
        tbl[6] = 12'h401; tbl[7] = 12'h201; tbl[8] = 12'h131; tbl[9] = 12'h001; tbl[10] = 12'h009;
        do_reset();
        instr_len = 2'd2;
        e.nbytes = 2; e.ncyc = 8; e.pc = 16'hF002;
        sb.push_back(e);
        for (int c = 1; c <= 10; c++) begin
            if (c > 1) begin @(negedge clk); #1; end
            checks++;
            if (obs !== tbl[c]) begin
                errors++;
                $display("FAIL ldi_trace_c%0d: %h, want %h", c, obs, tbl[c]);
            end
            if (c == 2 || c == 6) begin
                checks++;
                if (pc !== ((c == 2) ? 16'hF000 : 16'hF001)) begin
                    errors++;
                    $display("FAIL ldi_mar_pc_c%0d: pc=%h", c, pc);
                end
            end
        end
        instr_len = 2'd1;
        e.nbytes = 1; e.ncyc = 4; e.pc = 16'hF003;
        sb.push_back(e);
        exec_done = 1'b1;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk); #1;
            exec_done = 1'b0;
            if (exec_start) got = 1;
        end
        is_halt = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (!got || obs !== 12'h004 || pc !== 16'hF003) begin
            errors++;
            $display("FAIL ldi_halt: got=%0d obs=%h pc=%h, want 1 004 F003", got, obs, pc);
        end
        is_halt = 1'b0;
    endtask

    task automatic test_lengths();
        do_reset();
        run_instr(2'd1, 1, 0);
        @(negedge clk); #1;
        checks++;
        if (exec_start !== 1'b0 || obs[11:4] !== 8'h00) begin
            errors++;
            $display("FAIL exec_hold: exec_start=%b strobes=%h, want 0 00", exec_start, obs[11:4]);
        end
        exec_done = 1'b1;
        run_instr(2'd3, 3, 1);
        exec_done = 1'b1;
        run_instr(2'd0, 1, 1);
    endtask

    task automatic test_back_to_back();
        int nmar;
        bit not_halted;
        do_reset();
        run_instr(2'd2, 2, 0);
        exec_done = 1'b1;
        run_instr(2'd3, 3, 1);
        is_halt = 1'b1; exec_done = 1'b1;
        nmar = 0; not_halted = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            if (load_mar_pc) nmar++;
            if (halted !== 1'b1) not_halted = 1;
        end
        checks++;
        if (nmar !== 0 || not_halted) begin
            errors++;
            $display("FAIL halt_terminal: load_mar_pc %0d times, halted dropped=%0d, want 0 0", nmar, not_halted);
        end
        is_halt = 1'b0; exec_done = 1'b0;
    endtask

    task automatic test_wait_states();
        exp_t e;
        int   rd_cycles, ir_c, xs_c;
        do_reset();
        instr_len = 2'd1; mem_ready = 1'b0;
        e.nbytes = 1; e.pc = 16'hF001;
`ifdef FETCH_WAIT_STATES_EN
        e.ncyc = 7;
`else
        e.ncyc = 4;
`endif
        sb.push_back(e);
        rd_cycles = 0; ir_c = 0; xs_c = 0;
        for (int c = 2; c <= 12; c++) begin
            @(negedge clk); #1;
            if (c == 6) mem_ready = 1'b1;
            if (mem_read) rd_cycles++;
            if (load_ir && ir_c == 0) ir_c = c;
            if (exec_start && xs_c == 0) xs_c = c;
        end
        checks++;
`ifdef FETCH_WAIT_STATES_EN
        if (rd_cycles !== 4 || ir_c !== 7 || xs_c !== 9) begin
            errors++;
            $display("FAIL wait_states: read=%0d ir@%0d exec@%0d, want 4 7 9", rd_cycles, ir_c, xs_c);
        end
`else
        if (rd_cycles !== 1 || ir_c !== 4 || xs_c !== 6) begin
            errors++;
            $display("FAIL wait_ignored: read=%0d ir@%0d exec@%0d, want 1 4 6", rd_cycles, ir_c, xs_c);
        end
`endif
        mem_ready = 1'b1;
    endtask

    task automatic test_reset_mid();
        bit found;
        do_reset();
        instr_len = 2'd2; found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk); #1;
            if (mem_read && byte_index == 2'd1) found = 1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL mid_find: READ_BYTE of byte 1 not reached");
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (obs !== 12'h800) begin
            errors++;
            $display("FAIL mid_reset_async: %h, want 800", obs);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (obs !== 12'h800) begin
            errors++;
            $display("FAIL mid_reset_init: %h, want 800", obs);
        end
        run_instr(2'd2, 2, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_clamp();
        test_ldi();
        test_lengths();
        test_back_to_back();
        test_wait_states();
        test_reset_mid();
        exec_done = 1'b1;
        @(negedge clk); #1;
        exec_done = 1'b0;
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL sb_final: %0d pending, want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
